delay_line_code_stepper: RTL
============================

Name: delay_line_code_stepper

Overview:
- Sits directly upstream of the 128-tap tristate-inverter delay line.
- Converts a binary delay-code request into the one-hot `ctl` and one-cold `ctl_b` control buses that drive the line.
- Walks the selected tap one position at a time toward the requested code, dwelling between steps, so the delayed clock never jumps across many taps in a single update.
- The SRAM BIST/timing controller issues requests over a valid/ready handshake and receives a done pulse once the new delay has settled.

Parameters:
- CONTROL_WIDTH, 128, number of delay-line taps; width of ctl/ctl_b.
- CODE_WIDTH, 7, width of the binary code; must satisfy 2^CODE_WIDTH >= CONTROL_WIDTH.
- STEP_CYCLES, 4, clock cycles dwelt per single-tap step and for final settle; must be >= 1.

Ports:
- clock  input  1  block clock.
- reset  input  1  asynchronous, active-high reset.
- code_valid  input  1  request valid.
- code_ready  output  1  block can accept a request; high only in IDLE.
- code  input  CODE_WIDTH  requested target tap index.
- ctl  output  CONTROL_WIDTH  one-hot tap select to the delay line; registered.
- ctl_b  output  CONTROL_WIDTH  bitwise complement of ctl; registered.
- cur_code  output  CODE_WIDTH  binary index of the currently selected tap.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  single-cycle pulse when a request completes.

Behaviour:
- **State:** FSM states are IDLE, STEP and SETTLE. Registers are cur_idx, target, dwell counter (clog2(STEP_CYCLES) bits) and done.
- **Reset** (asynchronous, takes effect immediately, including mid-operation):
  - state = IDLE, cur_idx = 0, target = 0, dwell = 0, done = 0.
  - ctl = 1 (bit 0 only), ctl_b = ~1.
  - code_ready = 1, busy = 0.
  - No done pulse is issued for an interrupted request.
- **Output invariants:**
  - ctl is exactly one-hot at every cycle, including reset.
  - ctl_b == ~ctl at every cycle.
  - ctl bit cur_idx is the set bit.
  - ctl and ctl_b update on the same edge as cur_idx; no combinational path from code to ctl.
- **Accept:**
  - Handshake fires on code_valid && code_ready at edge k.
  - target <= min(code, CONTROL_WIDTH-1); out-of-range codes clamp to the top tap.
  - dwell <= 0.
  - Next state: STEP if the clamped target != cur_idx, else SETTLE.
  - code_valid while not ready is ignored; target is not modified.
- **STEP:**
  - dwell increments each cycle.
  - When dwell == STEP_CYCLES-1: cur_idx moves by exactly +1 or -1 toward target, and dwell <= 0.
  - If the new cur_idx == target, the next state is SETTLE.
- **SETTLE:**
  - Dwell counts STEP_CYCLES cycles; cur_idx is unchanged.
  - On the final cycle: state <= IDLE and done <= 1 for one cycle.
- **Latency:**
  - For distance d = |target - cur_idx|, tap changes occur at edges k+S, k+2S, ..., k+dS, where S = STEP_CYCLES.
  - done is high in the cycle following edge k+(d+1)S.
  - code_ready rises in that same cycle.
  - A new request may be accepted in the cycle in which done is high.
- **Width and wrap:**
  - cur_idx never wraps.
  - cur_idx stays within 0..CONTROL_WIDTH-1 by construction, because it only moves toward a clamped target.
- **STEP_CYCLES = 1:** dwell is held at 0 and steps occur on every cycle.

Test Plan:
1. Assert then release reset -> ctl = 128'h1, ctl_b = ~128'h1, cur_code = 0, code_ready = 1, busy = 0, done = 0.
2. From 0, request code = 5 accepted at edge 0 (S = 4):
   - cur_code becomes 1, 2, 3, 4, 5 at edges 4, 8, 12, 16, 20.
   - done pulses once after edge 24.
   - ctl = 1<<5.
   - Checker confirms ctl is one-hot and ctl_b == ~ctl every cycle.
3. From 5, request code = 2:
   - cur_code becomes 4, 3, 2 at edges 4, 8, 12.
   - done after edge 16.
   - busy is high for exactly 16 cycles.
4. From 2, request code = 2 -> ctl never changes; done after edge 4.
5. During a 0->10 walk, hold code_valid with code = 100 -> code_ready = 0, request ignored, final cur_code = 10.
6. Boundary and reset cases:
   - Request code = 127 -> cur_code ends at 127, bit 127 set.
   - With CONTROL_WIDTH = 100, request code = 120 -> clamps to 99.
   - Assert reset asynchronously while cur_code = 3 mid-walk -> immediately ctl = 1, cur_code = 0, IDLE, no done.

Source files
------------

// File: rtl/delay_line_code_stepper.sv
// Binary-code to one-hot tap select for the tristate-inverter delay line.
// Walks one tap per dwell period toward each request, then settles and pulses done.
module delay_line_code_stepper #(
    parameter int CONTROL_WIDTH = 128,
    parameter int CODE_WIDTH    = 7,
    parameter int STEP_CYCLES   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     code_valid,
    output logic                     code_ready,
    input  logic [CODE_WIDTH-1:0]    code,
    output logic [CONTROL_WIDTH-1:0] ctl,
    output logic [CONTROL_WIDTH-1:0] ctl_b,
    output logic [CODE_WIDTH-1:0]    cur_code,
    output logic                     busy,
    output logic                     done
);

    localparam int DWELL_WIDTH =
        (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DWELL_WIDTH-1:0] DWELL_LAST =
        DWELL_WIDTH'(STEP_CYCLES - 1);
    localparam logic [CODE_WIDTH-1:0] TOP_IDX =
        CODE_WIDTH'(CONTROL_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        SETTLE
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic [CODE_WIDTH-1:0]    cur_idx;
    logic [CODE_WIDTH-1:0]    cur_idx_n;
    logic [CODE_WIDTH-1:0]    target;
    logic [CODE_WIDTH-1:0]    target_n;
    logic [DWELL_WIDTH-1:0]   dwell;
    logic [DWELL_WIDTH-1:0]   dwell_n;
    logic                     done_n;
    logic [CODE_WIDTH-1:0]    clamped;
    logic                     dwell_last;
    logic [CONTROL_WIDTH-1:0] ctl_n;

    // Out-of-range requests pin to the top tap so cur_idx can never leave the line.
    assign clamped    = (code > TOP_IDX) ? TOP_IDX : code;
    assign dwell_last = (dwell == DWELL_LAST);

    assign code_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign cur_code   = cur_idx;

    always_comb begin
        state_n   = state;
        cur_idx_n = cur_idx;
        target_n  = target;
        dwell_n   = dwell;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (code_valid) begin
                    target_n = clamped;
                    dwell_n  = '0;
                    state_n  = (clamped != cur_idx) ? STEP : SETTLE;
                end
            end
            STEP: begin
                if (dwell_last) begin
                    dwell_n = '0;
                    if (target > cur_idx) begin
                        cur_idx_n = cur_idx + CODE_WIDTH'(1);
                    end else begin
                        cur_idx_n = cur_idx - CODE_WIDTH'(1);
                    end
                    if (cur_idx_n == target) begin
                        state_n = SETTLE;
                    end
                end else begin
                    dwell_n = dwell + DWELL_WIDTH'(1);
                end
            end
            SETTLE: begin
                if (dwell_last) begin
                    dwell_n = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    dwell_n = dwell + DWELL_WIDTH'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Tap select is decoded from the next index so ctl moves on the same edge.
    always_comb begin
        ctl_n = CONTROL_WIDTH'(1) << cur_idx_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cur_idx <= '0;
            target  <= '0;
            dwell   <= '0;
            done    <= 1'b0;
            ctl     <= CONTROL_WIDTH'(1);
            ctl_b   <= ~CONTROL_WIDTH'(1);
        end else begin
            state   <= state_n;
            cur_idx <= cur_idx_n;
            target  <= target_n;
            dwell   <= dwell_n;
            done    <= done_n;
            ctl     <= ctl_n;
            ctl_b   <= ~ctl_n;
        end
    end

endmodule
